// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, sl_bus bit positions,
// stall encoding and the decoded view of the EX->MEM payload.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 91;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_TO_ID_WD = 38;
    localparam int STALL_WD     = 6;

    // Positions inside the 15-bit sl_bus; [6:0] are reserved.
    localparam int SL_LW  = 14;
    localparam int SL_SW  = 13;
    localparam int SL_LB  = 12;
    localparam int SL_LBU = 11;
    localparam int SL_LH  = 10;
    localparam int SL_LHU = 9;
    localparam int SL_SB  = 8;
    localparam int SL_SH  = 7;

    localparam int MEM_STALL_BIT = 3;
    localparam int WB_STALL_BIT  = 4;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef struct packed {
        logic [14:0] sl_bus;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic lw;
        logic lb;
        logic lbu;
        logic lh;
        logic lhu;
    } load_kind_t;

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load formatter: picks the addressed byte/halfword out of the SRAM word
// and sign- or zero-extends it to 32 bits.
import mem_stage_pkg::*;

module mem_load_ext (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  load_kind_t  kind,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata[7:0];
        half_sel  = rdata[15:0];
        load_data = '0;

        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        // Halfword selection ignores addr[0]; misalignment is not trapped here.
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        if (kind.lw)
            load_data = rdata;
        else if (kind.lb)
            load_data = {{24{byte_sel[7]}}, byte_sel};
        else if (kind.lbu)
            load_data = {24'd0, byte_sel};
        else if (kind.lh)
            load_data = {{16{half_sel[15]}}, half_sel};
        else if (kind.lhu)
            load_data = {16'd0, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX payload, holds SRAM read data across stalls,
// formats loads and drives the writeback and ID forwarding buses.
import mem_stage_pkg::*;

module mem_stage (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
    output logic                    mem_is_load
);

    ex_to_mem_t  r;
    logic        hold_v;
    logic [31:0] hold_d;
    logic        mem_stop;
    logic        wb_stop;
    load_kind_t  kind;
    logic [31:0] rdata_eff;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        unused_bits;

    assign mem_stop = (stall[MEM_STALL_BIT] == STOP);
    assign wb_stop  = (stall[WB_STALL_BIT] == STOP);

    // A bubble is inserted when this stage stops but the next one keeps moving.
    always_ff @(posedge clk) begin
        if (!resetn)
            r <= '0;
        else if (mem_stop && !wb_stop)
            r <= '0;
        else if (!mem_stop)
            r <= ex_to_mem_t'(ex_to_mem_bus);
    end

    // The SRAM output drifts while the stage is frozen, so keep the first stalled sample.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_v <= 1'b0;
            hold_d <= '0;
        end else if (mem_stop) begin
            if (!hold_v) begin
                hold_v <= 1'b1;
                hold_d <= data_sram_rdata;
            end
        end else begin
            hold_v <= 1'b0;
        end
    end

    assign rdata_eff = hold_v ? hold_d : data_sram_rdata;

    assign kind.lw  = r.sl_bus[SL_LW];
    assign kind.lb  = r.sl_bus[SL_LB];
    assign kind.lbu = r.sl_bus[SL_LBU];
    assign kind.lh  = r.sl_bus[SL_LH];
    assign kind.lhu = r.sl_bus[SL_LHU];

    assign mem_is_load = |kind;

    mem_load_ext u_load_ext (
        .rdata     (rdata_eff),
        .addr      (r.ex_result[1:0]),
        .kind      (kind),
        .load_data (load_data)
    );

    // sel_rf_res without any load bit falls back to the ALU result.
    assign rf_wdata = (r.sel_rf_res && mem_is_load) ? load_data : r.ex_result;

    assign mem_to_wb_bus = {r.pc, r.rf_we, r.rf_waddr, rf_wdata};
    assign mem_to_id_bus = {r.rf_we, r.rf_waddr, rf_wdata};

    // Store controls, reserved sl_bus bits and other stages' stall flags are not used here.
    assign unused_bits = ^{r.ram_en, r.ram_wen, r.sl_bus[SL_SW], r.sl_bus[SL_SB],
                           r.sl_bus[SL_SH], r.sl_bus[6:0], stall[STALL_WD-1],
                           stall[MEM_STALL_BIT-1:0]};

endmodule
